// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory bridge.
//   dmem_state_t : bridge FSM state encoding
//   SZ_B/SZ_H/SZ_W : access size codes as driven by the core (3 behaves as word)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/dmem_strb.sv
// dmem_strb: byte-enable generation and misalignment detection for one access.
// Ports:
//   addr_lo    in  2 : low address bits of the access
//   size       in  2 : SZ_B / SZ_H / SZ_W (3 is treated as word)
//   strb       out 4 : byte enables for the 32-bit bus word
//   misaligned out 1 : half on an odd address, or word not on a 4-byte boundary
module dmem_strb
  import dmem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic [3:0] strb,
  output logic       misaligned
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    strb       = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SZ_B: strb = 4'b0001 << addr_lo;
      SZ_H: begin
        strb       = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      default: begin
        strb       = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's held load/store strobes into a request/grant/
// response bus transaction, with byte strobes, misalignment errors and a
// response timeout.
// Parameters:
//   TIMEOUT : max cycles from request to response (0 disables the timeout)
//   AW      : address width
// Ports:
//   clk, rst         : clock; asynchronous active-low reset
//   i_read_en        : core load request, held until o_read_vd
//   i_write_en       : core store request, held while o_exstall is high
//   i_addr/i_wdata/i_size : access address, lane-aligned store data, size code
//   o_rdata          : registered load data, valid with o_read_vd
//   o_read_vd        : one-cycle load-complete pulse
//   o_exstall        : store back-pressure to the core (combinational)
//   o_err            : one-cycle pulse on misalignment or timeout
//   o_bus_req/we/addr/wdata/wstrb : registered bus request fields
//   i_bus_gnt/i_bus_rvalid/i_bus_rdata : bus grant, response and read data
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read_en,
  input  logic          i_write_en,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [1:0]    i_size,
  output logic [31:0]   o_rdata,
  output logic          o_read_vd,
  output logic          o_exstall,
  output logic          o_err,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [31:0]   o_bus_wdata,
  output logic [3:0]    o_bus_wstrb,
  input  logic          i_bus_gnt,
  input  logic          i_bus_rvalid,
  input  logic [31:0]   i_bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dmem_state_t state;
  logic [CW-1:0] cnt;
  logic          is_write;   // latched direction of the access in flight
  logic [3:0]    strb;
  logic          misaligned;
  logic          timeout_hit;

  dmem_strb u_strb (
    .addr_lo    (i_addr[1:0]),
    .size       (i_size),
    .strb       (strb),
    .misaligned (misaligned)
  );

  // Last allowed cycle of a transaction; completion in this cycle still wins.
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);

  // Stall the store from the strobe cycle until DONE, so the core retires it
  // on the DONE edge.
  assign o_exstall = ((state == IDLE) && i_write_en) ||
                     (((state == REQ) || (state == RESP)) && is_write);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_write    <= 1'b0;
      o_rdata     <= '0;
      o_read_vd   <= 1'b0;
      o_err       <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_wstrb <= '0;
    end else begin
      // Completion flags are pulses that only the transition into DONE sets.
      o_read_vd <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_write_en || i_read_en) begin
            is_write <= i_write_en;  // store wins when both strobes are up
            if (misaligned) begin
              state     <= DONE;
              o_err     <= 1'b1;
              o_read_vd <= !i_write_en;
              o_rdata   <= '0;
            end else begin
              state       <= REQ;
              cnt         <= '0;
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_write_en;
              o_bus_addr  <= {i_addr[AW-1:2], 2'b00};
              o_bus_wdata <= i_wdata;
              o_bus_wstrb <= strb;
            end
          end
        end

        REQ: begin
          if (i_bus_gnt && i_bus_rvalid) begin
            state     <= DONE;
            o_bus_req <= 1'b0;
            o_rdata   <= i_bus_rdata;
            o_read_vd <= !is_write;
          end else if (timeout_hit) begin
            state     <= DONE;
            o_bus_req <= 1'b0;
            o_err     <= 1'b1;
            o_read_vd <= !is_write;
            o_rdata   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            if (i_bus_gnt) begin
              state     <= RESP;
              o_bus_req <= 1'b0;
            end
          end
        end

        RESP: begin
          if (i_bus_rvalid) begin
            state     <= DONE;
            o_rdata   <= i_bus_rdata;
            o_read_vd <= !is_write;
          end else if (timeout_hit) begin
            state     <= DONE;
            o_err     <= 1'b1;
            o_read_vd <= !is_write;
            o_rdata   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // The core still presents the finished instruction here, so nothing
        // new is accepted.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
